// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared widths, screen geometry and arbiter state type for the VGA    |
// | draw path.                                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int X_W_DEF           = 8;
  localparam int Y_W_DEF           = 7;
  localparam int C_W_DEF           = 3;
  localparam int SCREEN_W          = 160;
  localparam int SCREEN_H          = 120;
  localparam int TRANSP_COLOUR_DEF = 0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker                                                            |
// | Combinational rotating-priority picker: first set request at or      |
// | after the pointer, wrapping. Pointer tied to 0 gives fixed priority. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_picker
  import vga_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_oh,
  output logic [PTR_W-1:0] o_grant_idx
);

  logic w_found;

  // Scan indices >= pointer first, then wrap to indices below the pointer.
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
        w_found       = 1'b1;
        o_grant_oh[j] = 1'b1;
        o_grant_idx   = PTR_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_req[j] && (j < int'(i_ptr))) begin
        w_found       = 1'b1;
        o_grant_oh[j] = 1'b1;
        o_grant_idx   = PTR_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_draw_arbiter                                                     |
// | N-channel valid/ready pixel arbiter with atomic bursts, fixed or     |
// | round-robin priority, transparent-colour drop and a registered,      |
// | backpressured output stage feeding the VGA adapter.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_draw_arbiter
  import vga_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int X_W           = X_W_DEF,
  parameter int Y_W           = Y_W_DEF,
  parameter int C_W           = C_W_DEF,
  parameter int RR_EN         = 1,
  parameter int TRANSP_EN     = 0,
  parameter int TRANSP_COLOUR = TRANSP_COLOUR_DEF
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [N_CH-1:0]           in_valid,
  output logic [N_CH-1:0]           in_ready,
  input  logic [N_CH-1:0]           in_last,
  input  logic [N_CH*X_W-1:0]       in_x,
  input  logic [N_CH*Y_W-1:0]       in_y,
  input  logic [N_CH*C_W-1:0]       in_colour,
  output logic [X_W-1:0]            out_x,
  output logic [Y_W-1:0]            out_y,
  output logic [C_W-1:0]            out_colour,
  output logic                      out_plot,
  input  logic                      out_ready,
  output logic [$clog2(N_CH)-1:0]   out_chan,
  output logic                      busy
);

  localparam int CH_W = $clog2(N_CH);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [CH_W-1:0] r_lock;
  logic [CH_W-1:0] w_pick_ptr;
  logic [N_CH-1:0] w_pick_oh;
  logic [CH_W-1:0] w_pick_idx;
  logic [CH_W-1:0] w_sel_idx;
  logic            w_slot_free;
  logic            w_acc;
  logic            w_load;
  logic            w_transp;
  logic [X_W-1:0]  w_x;
  logic [Y_W-1:0]  w_y;
  logic [C_W-1:0]  w_col;
  logic            w_last;

  logic [X_W-1:0]  r_x;
  logic [Y_W-1:0]  r_y;
  logic [C_W-1:0]  r_col;
  logic [CH_W-1:0] r_chan;
  logic            r_plot;

  // The output register can take a new pixel when empty or being drained.
  assign w_slot_free = !r_plot || out_ready;
  assign w_sel_idx   = (r_state == BURST) ? r_lock : w_pick_idx;
  assign w_acc       = |(in_valid & in_ready);
  assign w_transp    = (TRANSP_EN != 0) && (w_col == C_W'(TRANSP_COLOUR));
  assign w_load      = w_acc && !w_transp;

  rr_picker #(
    .N     (N_CH),
    .PTR_W (CH_W)
  ) u_picker (
    .i_req       (in_valid),
    .i_ptr       (w_pick_ptr),
    .o_grant_oh  (w_pick_oh),
    .o_grant_idx (w_pick_idx)
  );

  // Round-robin pointer advances past the granted channel on each burst end;
  // fixed priority simply scans from channel 0.
  generate
    if (RR_EN != 0) begin : g_rr
      logic [CH_W-1:0] r_ptr;
      // Pointer update on the final beat of a burst.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_ptr <= '0;
        end else if (w_acc && w_last) begin
          r_ptr <= (w_sel_idx == CH_W'(N_CH - 1)) ? '0 : w_sel_idx + CH_W'(1);
        end
      end
      assign w_pick_ptr = r_ptr;
    end else begin : g_fixed
      assign w_pick_ptr = '0;
    end
  endgenerate

  // Steer the selected channel's beat onto the internal data bus.
  always_comb begin
    w_x    = '0;
    w_y    = '0;
    w_col  = '0;
    w_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_sel_idx == CH_W'(i)) begin
        w_x    = in_x[i*X_W +: X_W];
        w_y    = in_y[i*Y_W +: Y_W];
        w_col  = in_colour[i*C_W +: C_W];
        w_last = in_last[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: enter BURST on a non-final beat, leave on the final beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc && !w_last) w_state_nxt = BURST;
      BURST:   if (w_acc && w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready outputs: picker grant in IDLE, locked channel only in BURST;
  // forced low while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (resetn && w_slot_free) begin
      if (r_state == BURST) begin
        for (int i = 0; i < N_CH; i++) begin
          in_ready[i] = (r_lock == CH_W'(i));
        end
      end else begin
        in_ready = w_pick_oh;
      end
    end
  end

  // Remember which channel owns the burst; any accepted beat refreshes it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lock <= '0;
    end else if (w_acc) begin
      r_lock <= w_sel_idx;
    end
  end

  // Output pixel register: load on visible accept, drop strobe when drained.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= '0;
      r_chan <= '0;
      r_plot <= 1'b0;
    end else if (w_load) begin
      r_x    <= w_x;
      r_y    <= w_y;
      r_col  <= w_col;
      r_chan <= w_sel_idx;
      r_plot <= 1'b1;
    end else if (out_ready) begin
      r_plot <= 1'b0;
    end
  end

  assign out_x      = r_x;
  assign out_y      = r_y;
  assign out_colour = r_col;
  assign out_chan   = r_chan;
  assign out_plot   = r_plot;
  assign busy       = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_draw_arbiter                                                  |
// | Directed bench: a 2-channel transparent-enabled instance plus        |
// | 3-channel round-robin and fixed-priority instances on shared inputs. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_draw_arbiter;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  // 2-channel instance A
  logic [1:0]  a_valid, a_ready, a_last;
  logic [15:0] a_x;
  logic [13:0] a_y;
  logic [5:0]  a_col;
  logic [7:0]  a_ox;
  logic [6:0]  a_oy;
  logic [2:0]  a_oc;
  logic        a_plot, a_ordy, a_busy;
  logic [0:0]  a_chan;
  logic [20:0] a_vec;

  // 3-channel instances B (round-robin) and C (fixed priority)
  logic [2:0]  bc_valid, bc_last, b_ready, c_ready;
  logic [23:0] bc_x;
  logic [20:0] bc_y;
  logic [8:0]  bc_col;
  logic        bc_ordy;
  logic [7:0]  b_ox, c_ox;
  logic [6:0]  b_oy, c_oy;
  logic [2:0]  b_oc, c_oc;
  logic        b_plot, c_plot, b_busy, c_busy;
  logic [1:0]  b_chan, c_chan;

  assign a_vec = {a_plot, a_busy, a_chan, a_ox, a_oy, a_oc};

  vga_draw_arbiter #(.N_CH(2), .RR_EN(1), .TRANSP_EN(1), .TRANSP_COLOUR(0)) u_a (
    .clock(clk), .resetn(resetn), .in_valid(a_valid), .in_ready(a_ready),
    .in_last(a_last), .in_x(a_x), .in_y(a_y), .in_colour(a_col),
    .out_x(a_ox), .out_y(a_oy), .out_colour(a_oc), .out_plot(a_plot),
    .out_ready(a_ordy), .out_chan(a_chan), .busy(a_busy)
  );

  vga_draw_arbiter #(.N_CH(3), .RR_EN(1)) u_b (
    .clock(clk), .resetn(resetn), .in_valid(bc_valid), .in_ready(b_ready),
    .in_last(bc_last), .in_x(bc_x), .in_y(bc_y), .in_colour(bc_col),
    .out_x(b_ox), .out_y(b_oy), .out_colour(b_oc), .out_plot(b_plot),
    .out_ready(bc_ordy), .out_chan(b_chan), .busy(b_busy)
  );

  vga_draw_arbiter #(.N_CH(3), .RR_EN(0)) u_c (
    .clock(clk), .resetn(resetn), .in_valid(bc_valid), .in_ready(c_ready),
    .in_last(bc_last), .in_x(bc_x), .in_y(bc_y), .in_colour(bc_col),
    .out_x(c_ox), .out_y(c_oy), .out_colour(c_oc), .out_plot(c_plot),
    .out_ready(bc_ordy), .out_chan(c_chan), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int ch, input int x, input int y, input int c, input logic l);
    a_x[ch*8 +: 8]   = 8'(x);
    a_y[ch*7 +: 7]   = 7'(y);
    a_col[ch*3 +: 3] = 3'(c);
    a_last[ch]       = l;
  endtask

  task automatic test_reset();
    a_valid  = 2'b11;
    bc_valid = 3'b111;
    #1;
    n_vec++;
    if ({a_ready, b_ready, c_ready} !== 8'h00) begin
      n_err++; $display("FAIL reset_ready: got %h want 00", {a_ready, b_ready, c_ready});
    end
    tick();
    n_vec++;
    if (a_vec !== 21'h0) begin
      n_err++; $display("FAIL reset_out: got %h want 000000", a_vec);
    end
    n_vec++;
    if ({b_plot, b_busy, b_chan, c_plot, c_busy, c_chan} !== 8'h00) begin
      n_err++; $display("FAIL reset_bc: got %h want 00", {b_plot, b_busy, b_chan, c_plot, c_busy, c_chan});
    end
    a_valid  = 2'b00;
    bc_valid = 3'b000;
    resetn   = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_a(1, 10, 20, 5, 1'b1);
    a_valid = 2'b10;
    #1;
    n_vec++;
    if (a_ready !== 2'b10) begin
      n_err++; $display("FAIL single_ready: got %b want 10", a_ready);
    end
    tick();
    a_valid = 2'b00;
    n_vec++;
    if (a_vec !== {1'b1, 1'b0, 1'b1, 8'd10, 7'd20, 3'd5}) begin
      n_err++; $display("FAIL single_out: got %h want %h", a_vec, {1'b1, 1'b0, 1'b1, 8'd10, 7'd20, 3'd5});
    end
    tick();
    n_vec++;
    if (a_plot !== 1'b0) begin
      n_err++; $display("FAIL single_plot_drop: got %b want 0", a_plot);
    end
  endtask

  task automatic test_burst();
    logic [20:0] e;
    set_a(1, 99, 9, 7, 1'b1);
    a_valid = 2'b11;
    for (int b = 0; b < 4; b++) begin
      set_a(0, b + 1, b + 1, b + 1, (b == 3));
      #1;
      n_vec++;
      if (a_ready !== 2'b01) begin
        n_err++; $display("FAIL burst_ready beat %0d: got %b want 01", b, a_ready);
      end
      tick();
      e = {1'b1, (b < 3), 1'b0, 8'(b + 1), 7'(b + 1), 3'(b + 1)};
      n_vec++;
      if (a_vec !== e) begin
        n_err++; $display("FAIL burst_out beat %0d: got %h want %h", b, a_vec, e);
      end
    end
    a_valid = 2'b10;
    #1;
    n_vec++;
    if (a_ready !== 2'b10) begin
      n_err++; $display("FAIL burst_handover_ready: got %b want 10", a_ready);
    end
    tick();
    a_valid = 2'b00;
    n_vec++;
    if (a_vec !== {1'b1, 1'b0, 1'b1, 8'd99, 7'd9, 3'd7}) begin
      n_err++; $display("FAIL burst_handover_out: got %h want %h", a_vec, {1'b1, 1'b0, 1'b1, 8'd99, 7'd9, 3'd7});
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [20:0] e;
    a_valid = 2'b10;
    for (int k = 0; k < 2; k++) begin
      set_a(1, 40 + k, k, k + 1, 1'b0);
      tick();
      e = {1'b1, 1'b1, 1'b1, 8'(40 + k), 7'(k), 3'(k + 1)};
      n_vec++;
      if (a_vec !== e) begin
        n_err++; $display("FAIL bp_pre beat %0d: got %h want %h", k, a_vec, e);
      end
    end
    set_a(1, 42, 2, 3, 1'b0);
    a_ordy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_vec++;
      if (a_ready !== 2'b00) begin
        n_err++; $display("FAIL bp_ready stall %0d: got %b want 00", s, a_ready);
      end
      tick();
      e = {1'b1, 1'b1, 1'b1, 8'd41, 7'd1, 3'd2};
      n_vec++;
      if (a_vec !== e) begin
        n_err++; $display("FAIL bp_hold stall %0d: got %h want %h", s, a_vec, e);
      end
    end
    a_ordy = 1'b1;
    #1;
    n_vec++;
    if (a_ready !== 2'b10) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 10", a_ready);
    end
    tick();
    n_vec++;
    if (a_vec !== {1'b1, 1'b1, 1'b1, 8'd42, 7'd2, 3'd3}) begin
      n_err++; $display("FAIL bp_beat2: got %h want %h", a_vec, {1'b1, 1'b1, 1'b1, 8'd42, 7'd2, 3'd3});
    end
    set_a(1, 43, 3, 4, 1'b1);
    tick();
    a_valid = 2'b00;
    n_vec++;
    if (a_vec !== {1'b1, 1'b0, 1'b1, 8'd43, 7'd3, 3'd4}) begin
      n_err++; $display("FAIL bp_beat3: got %h want %h", a_vec, {1'b1, 1'b0, 1'b1, 8'd43, 7'd3, 3'd4});
    end
    tick();
  endtask

  task automatic test_transparency();
    int          cols [4];
    logic [20:0] exp_v [4];
    int          plots;
    cols  = '{3, 0, 0, 6};
    exp_v = '{{1'b1, 1'b1, 1'b0, 8'd50, 7'd0, 3'd3},
              {1'b0, 1'b1, 1'b0, 8'd50, 7'd0, 3'd3},
              {1'b0, 1'b1, 1'b0, 8'd50, 7'd0, 3'd3},
              {1'b1, 1'b0, 1'b0, 8'd53, 7'd3, 3'd6}};
    plots = 0;
    a_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      set_a(0, 50 + k, k, cols[k], (k == 3));
      #1;
      n_vec++;
      if (a_ready !== 2'b01) begin
        n_err++; $display("FAIL transp_ready beat %0d: got %b want 01", k, a_ready);
      end
      tick();
      if (a_plot === 1'b1) plots++;
      n_vec++;
      if (a_vec !== exp_v[k]) begin
        n_err++; $display("FAIL transp_out beat %0d: got %h want %h", k, a_vec, exp_v[k]);
      end
    end
    a_valid = 2'b00;
    n_vec++;
    if (plots !== 2) begin
      n_err++; $display("FAIL transp_plot_count: got %0d want 2", plots);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    a_valid = 2'b01;
    for (int k = 0; k < 2; k++) begin
      set_a(0, 60 + k, k, k + 1, 1'b0);
      tick();
    end
    n_vec++;
    if (a_vec !== {1'b1, 1'b1, 1'b0, 8'd61, 7'd1, 3'd2}) begin
      n_err++; $display("FAIL rstmid_pre: got %h want %h", a_vec, {1'b1, 1'b1, 1'b0, 8'd61, 7'd1, 3'd2});
    end
    a_valid = 2'b11;
    set_a(1, 77, 7, 5, 1'b1);
    resetn = 1'b0;
    #1;
    n_vec++;
    if ({a_vec, a_ready} !== 23'h0) begin
      n_err++; $display("FAIL rstmid_abort: got %h want 000000", {a_vec, a_ready});
    end
    #1;
    resetn  = 1'b1;
    a_valid = 2'b10;
    #1;
    n_vec++;
    if (a_ready !== 2'b10) begin
      n_err++; $display("FAIL rstmid_regrant: got %b want 10", a_ready);
    end
    tick();
    a_valid = 2'b00;
    n_vec++;
    if (a_vec !== {1'b1, 1'b0, 1'b1, 8'd77, 7'd7, 3'd5}) begin
      n_err++; $display("FAIL rstmid_ch1: got %h want %h", a_vec, {1'b1, 1'b0, 1'b1, 8'd77, 7'd7, 3'd5});
    end
    tick();
  endtask

  task automatic test_rr_vs_priority();
    logic [11:0] eb, ec;
    for (int i = 0; i < 3; i++) begin
      bc_x[i*8 +: 8]   = 8'(100 + i);
      bc_y[i*7 +: 7]   = 7'(i);
      bc_col[i*3 +: 3] = 3'(i + 1);
    end
    bc_last  = 3'b111;
    bc_valid = 3'b111;
    #1;
    n_vec++;
    if ({b_ready, c_ready} !== 6'b001001) begin
      n_err++; $display("FAIL arb_first_ready: got %b want 001001", {b_ready, c_ready});
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      eb = {1'b1, 1'b0, 2'(k % 3), 8'(100 + (k % 3))};
      ec = {1'b1, 1'b0, 2'd0, 8'd100};
      n_vec++;
      if ({b_plot, b_busy, b_chan, b_ox} !== eb) begin
        n_err++; $display("FAIL rr_seq step %0d: got %h want %h", k, {b_plot, b_busy, b_chan, b_ox}, eb);
      end
      n_vec++;
      if ({c_plot, c_busy, c_chan, c_ox} !== ec) begin
        n_err++; $display("FAIL prio_seq step %0d: got %h want %h", k, {c_plot, c_busy, c_chan, c_ox}, ec);
      end
    end
    bc_valid = 3'b000;
    tick();
    n_vec++;
    if ({b_plot, c_plot} !== 2'b00) begin
      n_err++; $display("FAIL arb_drain: got %b want 00", {b_plot, c_plot});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    resetn   = 1'b0;
    a_valid  = '0; a_last = '0; a_x = '0; a_y = '0; a_col = '0; a_ordy = 1'b1;
    bc_valid = '0; bc_last = '0; bc_x = '0; bc_y = '0; bc_col = '0; bc_ordy = 1'b1;
    tick();
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_transparency();
    test_reset_mid();
    test_rr_vs_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
